bus_mem_responder: RTL and testbench

- Memory-mapped responder (slave) for the frame-buffer bus. It services one write port and one read port, each with waitrequest.
- Backed by an on-chip word RAM, with programmable wait latency per port and round-robin arbitration between ports.
- Stands in for the DRAM-side system on ctrl_clk, so the FIFO-based write/read initiators can be exercised and brought up without the memory controller.

---
 rtl/bus_mem_pkg.sv | 31 +++
 rtl/bus_mem_responder_if.sv | 33 +++
 rtl/bus_mem_ram.sv | 38 +++
 rtl/bus_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_bus_mem_responder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_pkg
// Description : Shared types and constants for the frame-buffer bus memory
//               responder: FSM state encoding, arbitration grant encoding,
//               wait-counter width and the RAM index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_e;

  // Wait counter holds latencies 0..15.
  localparam int c_CNT_W = 4;

  // Word-index width for a RAM of the given depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_responder_if
// Description : Write/read port pair of the frame-buffer bus, each with its
//               own waitrequest.
//   master : drives write_addr, iData, write, read_addr, read
//   slave  : drives write_waitrequest, oData, read_waitrequest
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] iData;
  logic              write;
  logic              write_waitrequest;
  logic [ADDR_W-1:0] read_addr;
  logic              read;
  logic [DATA_W-1:0] oData;
  logic              read_waitrequest;

  modport master (
    output write_addr, iData, write, read_addr, read,
    input  write_waitrequest, oData, read_waitrequest
  );

  modport slave (
    input  write_addr, iData, write, read_addr, read,
    output write_waitrequest, oData, read_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/bus_mem_ram.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_ram
// Description : Single-port synchronous word RAM, DEPTH x DATA_W, with a
//               registered read (data appears the cycle after the address).
//   clk     : clock
//   i_we    : write enable
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_responder
// Description : Memory-mapped responder for the frame-buffer bus. Serves one
//               write and one read port from an on-chip RAM with programmable
//               per-port wait latency and round-robin arbitration.
//   ctrl_clk : clock (rising edge)
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of the write/read port pair
//   oob_err  : sticky, set when an out-of-range access completes
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 32,
  parameter int                WR_LAT   = 1,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] OOB_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                 ctrl_clk,
  input  logic                 reset_n,
  bus_mem_responder_if.slave   bus,
  output logic                 oob_err
);

  localparam int                 c_IDX_W   = idx_width(DEPTH);
  localparam logic [c_CNT_W-1:0] c_WR_LAT  = c_CNT_W'(WR_LAT);
  localparam logic [c_CNT_W-1:0] c_RD_LAT  = c_CNT_W'(RD_LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  state_e               r_state,      w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt,        w_cnt_nxt;
  grant_e               r_last_grant, w_last_grant_nxt;
  logic [c_IDX_W-1:0]   r_idx,        w_idx_nxt;
  logic                 r_oob,        w_oob_nxt;
  logic [DATA_W-1:0]    r_wdata,      w_wdata_nxt;
  logic [DATA_W-1:0]    r_odata,      w_odata_nxt;
  logic                 r_oob_err,    w_oob_err_nxt;

  logic                 w_ram_we;
  logic [c_IDX_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]    w_ram_rdata;
  logic                 w_wr_wait;
  logic                 w_rd_wait;

  // Word index is addr[ADDR_W-1:2]; any set bit above the RAM index field
  // means the index is >= DEPTH.
  logic [c_IDX_W-1:0]   w_wr_idx;
  logic [c_IDX_W-1:0]   w_rd_idx;
  logic                 w_wr_oob;
  logic                 w_rd_oob;

  assign w_wr_idx = bus.write_addr[c_IDX_W+1:2];
  assign w_rd_idx = bus.read_addr[c_IDX_W+1:2];
  assign w_wr_oob = |bus.write_addr[ADDR_W-1:c_IDX_W+2];
  assign w_rd_oob = |bus.read_addr[ADDR_W-1:c_IDX_W+2];

  // Byte-lane bits carry no meaning on a word-aligned bus.
  wire w_unused_ok = &{1'b0, bus.write_addr[1:0], bus.read_addr[1:0]};

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_idx_nxt        = r_idx;
    w_oob_nxt        = r_oob;
    w_wdata_nxt      = r_wdata;
    w_odata_nxt      = r_odata;
    w_oob_err_nxt    = r_oob_err;
    w_ram_we         = 1'b0;
    w_ram_addr       = r_idx;
    w_wr_wait        = 1'b1;
    w_rd_wait        = 1'b1;

    case (r_state)
      IDLE: begin
        // Present the read index already in IDLE so the registered RAM
        // output is valid by the cnt==1 cycle even when RD_LAT is 1.
        w_ram_addr = w_rd_idx;
        if (bus.write && (!bus.read || r_last_grant == READ)) begin
          w_state_nxt      = WR_WAIT;
          w_cnt_nxt        = c_WR_LAT;
          w_idx_nxt        = w_wr_idx;
          w_oob_nxt        = w_wr_oob;
          w_wdata_nxt      = bus.iData;
          w_last_grant_nxt = WRITE;
        end else if (bus.read) begin
          w_state_nxt      = RD_WAIT;
          w_cnt_nxt        = c_RD_LAT;
          w_idx_nxt        = w_rd_idx;
          w_oob_nxt        = w_rd_oob;
          w_last_grant_nxt = READ;
        end
      end

      WR_WAIT: begin
        if (!bus.write) begin
          // Initiator withdrew: drop the transaction without side effects.
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_wr_wait   = 1'b0;
          w_ram_we    = !r_oob;
          if (r_oob) begin
            w_oob_err_nxt = 1'b1;
          end
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end

      RD_WAIT: begin
        if (!bus.read) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_rd_wait   = 1'b0;
          if (r_oob) begin
            w_oob_err_nxt = 1'b1;
          end
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            w_odata_nxt = r_oob ? OOB_DATA : w_ram_rdata;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= READ;
      r_idx        <= '0;
      r_oob        <= 1'b0;
      r_wdata      <= '0;
      r_odata      <= '0;
      r_oob_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_idx        <= w_idx_nxt;
      r_oob        <= w_oob_nxt;
      r_wdata      <= w_wdata_nxt;
      r_odata      <= w_odata_nxt;
      r_oob_err    <= w_oob_err_nxt;
    end
  end

  bus_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (c_IDX_W)
  ) u_ram (
    .clk     (ctrl_clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.write_waitrequest = w_wr_wait;
  assign bus.read_waitrequest  = w_rd_wait;
  assign bus.oData             = r_odata;
  assign oob_err               = r_oob_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bus_mem_responder
// Description : Directed self-checking bench. dut_a runs default latencies,
//               dut_b runs WR_LAT=0 / RD_LAT=3. Inputs change 1 ns after the
//               rising edge; outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mem_responder;

  logic ctrl_clk = 1'b0;
  logic reset_n  = 1'b0;
  logic oob_err_a;
  logic oob_err_b;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 ctrl_clk = ~ctrl_clk;

  bus_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
  bus_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

  bus_mem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(32), .WR_LAT(1), .RD_LAT(1),
    .OOB_DATA(32'hDEADBEEF)
  ) dut_a (
    .ctrl_clk (ctrl_clk),
    .reset_n  (reset_n),
    .bus      (bus_a),
    .oob_err  (oob_err_a)
  );

  bus_mem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(32), .WR_LAT(0), .RD_LAT(3),
    .OOB_DATA(32'hDEADBEEF)
  ) dut_b (
    .ctrl_clk (ctrl_clk),
    .reset_n  (reset_n),
    .bus      (bus_b),
    .oob_err  (oob_err_b)
  );

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    bus_a.write = 1'b0; bus_a.read = 1'b0; bus_a.write_addr = '0; bus_a.read_addr = '0; bus_a.iData = '0;
    bus_b.write = 1'b0; bus_b.read = 1'b0; bus_b.write_addr = '0; bus_b.read_addr = '0; bus_b.iData = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge ctrl_clk);
    #1 reset_n = 1'b1;
  endtask

  // Latency = falling edges seen with waitrequest high before the completion cycle.
  task automatic do_write(input bit sel, input logic [31:0] addr, input logic [31:0] data, output int lat);
    @(posedge ctrl_clk); #1;
    if (sel) begin bus_b.write_addr = addr; bus_b.iData = data; bus_b.write = 1'b1; end
    else     begin bus_a.write_addr = addr; bus_a.iData = data; bus_a.write = 1'b1; end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ctrl_clk);
      if (!(sel ? bus_b.write_waitrequest : bus_a.write_waitrequest)) break;
      lat++;
    end
    @(posedge ctrl_clk); #1;
    if (sel) bus_b.write = 1'b0; else bus_a.write = 1'b0;
  endtask

  task automatic do_read(input bit sel, input logic [31:0] addr, output int lat, output logic [31:0] data);
    @(posedge ctrl_clk); #1;
    if (sel) begin bus_b.read_addr = addr; bus_b.read = 1'b1; end
    else     begin bus_a.read_addr = addr; bus_a.read = 1'b1; end
    lat = 0;
    data = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ctrl_clk);
      data = sel ? bus_b.oData : bus_a.oData;
      if (!(sel ? bus_b.read_waitrequest : bus_a.read_waitrequest)) break;
      lat++;
    end
    @(posedge ctrl_clk); #1;
    if (sel) bus_b.read = 1'b0; else bus_a.read = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] d;
    int          n_ev;
    logic [31:0] ev_code [8];
    logic [31:0] ev_exp  [4];

    // ---------------- reset state ----------------
    apply_reset();
    @(negedge ctrl_clk);
    chk_vec("rst_wr_wait", bus_a.write_waitrequest, 1);
    chk_vec("rst_rd_wait", bus_a.read_waitrequest, 1);
    chk_vec("rst_odata",   bus_a.oData, 32'h0);
    chk_vec("rst_oob_err", oob_err_a, 0);
    chk_vec("rst_odata_b", bus_b.oData, 32'h0);

    // ---------------- 1: basic write then read ----------------
    do_write(0, 32'h08, 32'h11223344, lat);
    chk_vec("t1_wr_lat", lat, 2);
    do_read(0, 32'h08, lat, d);
    chk_vec("t1_rd_lat", lat, 2);
    chk_vec("t1_rd_data", d, 32'h11223344);

    // ---------------- 2: simultaneous requests, round robin ----------------
    // Event code = kind*256 + cycle, kind 1 = write done, 2 = read done.
    apply_reset();
    ev_exp[0] = 32'h102; ev_exp[1] = 32'h205; ev_exp[2] = 32'h108; ev_exp[3] = 32'h20B;
    @(posedge ctrl_clk); #1;
    bus_a.write_addr = 32'h04; bus_a.iData = 32'h0000_0404; bus_a.write = 1'b1;
    bus_a.read_addr  = 32'h0C; bus_a.read = 1'b1;
    n_ev = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ctrl_clk);
      if (!bus_a.write_waitrequest && n_ev < 8) begin ev_code[n_ev] = 32'h100 + c; n_ev++; end
      if (!bus_a.read_waitrequest  && n_ev < 8) begin ev_code[n_ev] = 32'h200 + c; n_ev++; end
    end
    @(posedge ctrl_clk); #1;
    bus_a.write = 1'b0; bus_a.read = 1'b0;
    chk_vec("t2_n_events", n_ev, 4);
    for (int k = 0; k < 4; k++) begin
      chk_vec($sformatf("t2_event%0d", k), (k < n_ev) ? ev_code[k] : 32'hFFFF_FFFF, ev_exp[k]);
    end

    // ---------------- 3: address sweep and out-of-band ----------------
    for (int a = 0; a <= 32'h40; a += 4) begin
      do_write(0, a, a, lat);
      chk_vec($sformatf("t3_sweep_lat_%0h", a), lat, 2);
    end
    chk_vec("t3_oob_before", oob_err_a, 0);
    do_read(0, 32'h40, lat, d);
    chk_vec("t3_rd_40", d, 32'h40);
    do_read(0, 32'h3C, lat, d);
    chk_vec("t3_rd_3c", d, 32'h3C);
    do_write(0, 32'h80, 32'h5555_AAAA, lat);
    chk_vec("t3_oob_wr_lat", lat, 2);
    chk_vec("t3_oob_after", oob_err_a, 1);
    do_read(0, 32'h00, lat, d);
    chk_vec("t3_rd_00_no_alias", d, 32'h0);
    do_read(0, 32'h80, lat, d);
    chk_vec("t3_rd_oob_lat", lat, 2);
    chk_vec("t3_rd_oob_data", d, 32'hDEADBEEF);

    // ---------------- 4: WR_LAT=0, RD_LAT=3 ----------------
    do_write(1, 32'h10, 32'hA5A5_0001, lat);
    chk_vec("t4_wr_lat", lat, 1);
    do_read(1, 32'h10, lat, d);
    chk_vec("t4_rd_lat", lat, 4);
    chk_vec("t4_rd_data", d, 32'hA5A5_0001);

    // ---------------- 5: read dropped mid-wait ----------------
    do_write(1, 32'h14, 32'h0000_BBBB, lat);
    chk_vec("t5_pre_wr_lat", lat, 1);
    @(posedge ctrl_clk); #1;
    bus_b.read_addr = 32'h14; bus_b.read = 1'b1;
    @(negedge ctrl_clk);
    chk_vec("t5_rd_wait_c0", bus_b.read_waitrequest, 1);
    @(posedge ctrl_clk); #1;
    bus_b.read = 1'b0;
    @(negedge ctrl_clk);
    chk_vec("t5_rd_wait_c1", bus_b.read_waitrequest, 1);
    do_write(1, 32'h18, 32'h0000_CCCC, lat);
    chk_vec("t5_next_wr_lat", lat, 1);
    chk_vec("t5_odata_kept", bus_b.oData, 32'hA5A5_0001);
    chk_vec("t5_oob_b", oob_err_b, 0);

    // ---------------- 6: async reset mid write ----------------
    do_write(0, 32'h20, 32'hCAFE_0020, lat);
    chk_vec("t6_pre_wr_lat", lat, 2);
    @(posedge ctrl_clk); #1;
    bus_a.write_addr = 32'h20; bus_a.iData = 32'h1234_5678; bus_a.write = 1'b1;
    repeat (3) @(negedge ctrl_clk);
    chk_vec("t6_wr_low_before_rst", bus_a.write_waitrequest, 0);
    #1 reset_n = 1'b0;
    #1;
    chk_vec("t6_wr_wait_async", bus_a.write_waitrequest, 1);
    chk_vec("t6_rd_wait_async", bus_a.read_waitrequest, 1);
    bus_a.write = 1'b0;
    @(posedge ctrl_clk); #1;
    reset_n = 1'b1;
    do_read(0, 32'h20, lat, d);
    chk_vec("t6_rd_lat", lat, 2);
    chk_vec("t6_word_kept", d, 32'hCAFE_0020);
    chk_vec("t6_oob_cleared", oob_err_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
